// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
// Latency: none, plain wires; timing is set by the arbiter itself.
// Backpressure: the owner releases with done_i or by dropping its request bit.
interface rr_arbiter16_if;
  logic [15:0] req_i;
  logic        done_i;
  logic [15:0] gnt_o;
  logic [3:0]  gnt_id_o;
  logic        gnt_valid_o;
  logic        timeout_o;

  // Arbiter side: consumes requests, produces registered grants.
  modport slave (
    input  req_i,
    input  done_i,
    output gnt_o,
    output gnt_id_o,
    output gnt_valid_o,
    output timeout_o
  );

  // Requester side: drives requests and release, observes grants.
  modport master (
    output req_i,
    output done_i,
    input  gnt_o,
    input  gnt_id_o,
    input  gnt_valid_o,
    input  timeout_o
  );
endinterface

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter sharing one resource among 16 requesters, with hold watchdog.
// Latency: grant registered 1 edge after an IDLE cycle; min 2 edges between grants.
// Backpressure: owner holds until done_i, request drop, or MAX_HOLD cycles elapse.
module rr_arbiter16 #(
  parameter int MAX_HOLD = 16  // legal range 1..256
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  rr_arbiter16_if.slave arb
);

  localparam int N     = 16;
  localparam int IDX_W = 4;
  // Last hold_cnt value of a grant; reaching it forces release at the next edge.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [7:0]       r_hold_cnt;
  logic [N-1:0]     r_gnt;
  logic [IDX_W-1:0] r_gnt_id;
  logic             r_gnt_vld;
  logic             r_timeout;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [7:0]       w_hold_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic [IDX_W-1:0] w_gnt_id_nxt;
  logic             w_gnt_vld_nxt;
  logic             w_timeout_nxt;

  logic [2*N-1:0]   w_req_dbl;
  logic [N-1:0]     w_req_rot;
  logic [IDX_W-1:0] w_win_off;
  logic             w_win_vld;
  logic [IDX_W-1:0] w_win_id;

  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_wd;
  logic             w_rel_any;

  // Rotate the request vector so bit 0 is the requester at ptr; the lowest set
  // bit of the rotated vector is then the first requester at or above ptr.
  assign w_req_dbl = {arb.req_i, arb.req_i};
  assign w_req_rot = w_req_dbl[r_ptr +: N];

  // Priority-encode the rotated requests (lowest index wins), then undo the rotation.
  always_comb begin
    w_win_off = '0;
    w_win_vld = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_win_off = IDX_W'(j);
        w_win_vld = 1'b1;
      end
    end
  end

  // Modulo-16 add comes for free from the 4-bit wrap.
  assign w_win_id = r_ptr + w_win_off;

  // Release causes for the current owner; the watchdog alone yields a timeout.
  assign w_rel_done = arb.done_i;
  assign w_rel_drop = ~arb.req_i[r_gnt_id];
  assign w_rel_wd   = (r_hold_cnt == HOLD_LAST);
  assign w_rel_any  = w_rel_done | w_rel_drop | w_rel_wd;

  // Next-state and next-output decode for the IDLE/BUSY grant FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_vld_nxt = r_gnt_vld;
    w_timeout_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_state_nxt   = BUSY;
          w_ptr_nxt     = w_win_id + IDX_W'(1);
          w_hold_nxt    = 8'd0;
          w_gnt_nxt     = N'(1) << w_win_id;
          w_gnt_id_nxt  = w_win_id;
          w_gnt_vld_nxt = 1'b1;
        end else begin
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = '0;
          w_gnt_vld_nxt = 1'b0;
        end
      end

      BUSY: begin
        w_hold_nxt = r_hold_cnt + 8'd1;
        if (w_rel_any) begin
          // Grant drops for at least one IDLE cycle; ptr only moves on a new grant.
          w_state_nxt   = IDLE;
          w_hold_nxt    = 8'd0;
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = '0;
          w_gnt_vld_nxt = 1'b0;
          w_timeout_nxt = w_rel_wd & ~w_rel_done & ~w_rel_drop;
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_hold_nxt    = 8'd0;
        w_gnt_nxt     = '0;
        w_gnt_id_nxt  = '0;
        w_gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears the grant without a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign arb.gnt_o       = r_gnt;
  assign arb.gnt_id_o    = r_gnt_id;
  assign arb.gnt_valid_o = r_gnt_vld;
  assign arb.timeout_o   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic.
// Expected grants come from an owner/pointer/hold-count model of the arbitration rules.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_rr_arbiter16;
  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n;

  rr_arbiter16_if arb();

  rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .arb     (arb)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: current owner (-1 when none), next search start, cycles held.
  int   m_owner;
  int   m_ptr;
  int   m_held;
  logic m_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_held    = 0;
    m_timeout = 1'b0;
  endtask

  // One rising edge of the arbitration rules, using the inputs applied before it.
  task automatic model_edge();
    if (m_owner < 0) begin
      m_timeout = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (arb.req_i[(m_ptr + i) % 16]) begin
          m_owner = (m_ptr + i) % 16;
          m_ptr   = (m_owner + 1) % 16;
          m_held  = 1;
          break;
        end
      end
    end else begin
      if (arb.done_i || !arb.req_i[m_owner] || m_held == MAX_HOLD) begin
        m_timeout = (m_held == MAX_HOLD) && !arb.done_i && arb.req_i[m_owner];
        m_owner   = -1;
      end else begin
        m_held++;
        m_timeout = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_gnt;
    logic [31:0] e_id;
    e_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    e_id  = (m_owner >= 0) ? 32'(m_owner) : 32'd0;
    check({tag, ".gnt"},     32'(arb.gnt_o),       e_gnt);
    check({tag, ".gnt_id"},  32'(arb.gnt_id_o),    e_id);
    check({tag, ".valid"},   32'(arb.gnt_valid_o), 32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(arb.timeout_o),   32'(m_timeout));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int          ids[4];
    int          exp_ids[4];
    int          vcnt;
    int          tcnt;
    logic [15:0] base;
    int          dprob;

    exp_ids = '{0, 4, 15, 0};

    // 1: reset and idle with no requests
    rst_n      = 1'b0;
    arb.req_i  = 16'h0000;
    arb.done_i = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle");

    // 2: sole requester, done pulse, re-grant after one IDLE cycle
    arb.req_i = 16'h0001;
    step("t2_grant");
    check("t2_gnt_first", 32'(arb.gnt_o), 32'h0001);
    arb.done_i = 1'b1;
    step("t2_release");
    check("t2_valid_released", 32'(arb.gnt_valid_o), 32'd0);
    arb.done_i = 1'b0;
    step("t2_regrant");
    check("t2_regrant_vld", 32'(arb.gnt_valid_o), 32'd1);
    check("t2_regrant_id", 32'(arb.gnt_id_o), 32'd0);

    // 3: rotation over 8011 from a fresh pointer
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n     = 1'b1;
    arb.req_i = 16'h8011;
    step("t3_grant");
    ids[0] = int'(arb.gnt_id_o);
    for (int g = 1; g < 4; g++) begin
      arb.done_i = 1'b1;
      step("t3_release");
      arb.done_i = 1'b0;
      step("t3_grant");
      ids[g] = int'(arb.gnt_id_o);
    end
    for (int g = 0; g < 4; g++) check($sformatf("t3_seq%0d", g), 32'(ids[g]), 32'(exp_ids[g]));

    // 4: watchdog on a held request
    arb.req_i = 16'h0100;
    step("t4_drop_prev");
    step("t4_grant");
    check("t4_id", 32'(arb.gnt_id_o), 32'd8);
    vcnt = 1;
    tcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step("t4_hold");
      if (arb.gnt_valid_o) begin
        vcnt++;
      end else begin
        tcnt = tcnt + int'(arb.timeout_o);
        break;
      end
    end
    check("t4_valid_cycles", 32'(vcnt), 32'(MAX_HOLD));
    check("t4_timeout_pulse", 32'(tcnt), 32'd1);
    step("t4_regrant");
    check("t4_regrant_id", 32'(arb.gnt_id_o), 32'd8);
    check("t4_timeout_cleared", 32'(arb.timeout_o), 32'd0);

    // 5a: owner drops its request mid-grant
    for (int i = 0; i < 3; i++) step("t5a_hold");
    arb.req_i = 16'h0000;
    step("t5a_drop");
    check("t5a_valid", 32'(arb.gnt_valid_o), 32'd0);
    check("t5a_timeout", 32'(arb.timeout_o), 32'd0);

    // 5b: done coincides with the last allowed hold cycle
    arb.req_i = 16'h0100;
    step("t5b_grant");
    for (int i = 0; i < MAX_HOLD - 1; i++) step("t5b_hold");
    arb.done_i = 1'b1;
    step("t5b_release");
    check("t5b_valid", 32'(arb.gnt_valid_o), 32'd0);
    check("t5b_timeout", 32'(arb.timeout_o), 32'd0);
    arb.done_i = 1'b0;

    // 6: asynchronous reset during a grant to id 3
    arb.req_i = 16'h0008;
    step("t6_grant3");
    check("t6_id3", 32'(arb.gnt_id_o), 32'd3);
    arb.req_i = 16'h0FFF;
    step("t6_hold");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_gnt", 32'(arb.gnt_o), 32'd0);
    check("t6_async_valid", 32'(arb.gnt_valid_o), 32'd0);
    check_all("t6_async");
    #2;
    rst_n = 1'b1;
    step("t6_after_reset");
    check("t6_first_id", 32'(arb.gnt_id_o), 32'd0);

    // Random traffic: per-phase request pattern and done rate, occasional bit flips
    for (int p = 0; p < 30; p++) begin
      base = 16'($urandom);
      if (p % 3 == 0) base = 16'd1 << $urandom_range(15, 0);
      dprob = p % 4;
      for (int c = 0; c < 20; c++) begin
        arb.req_i = base;
        if ($urandom_range(15, 0) == 0) arb.req_i = base ^ (16'd1 << $urandom_range(15, 0));
        arb.done_i = (dprob != 0) && ($urandom_range(7, 0) < 32'(dprob));
        step("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
